stack_ptr_unit: RTL and testbench

//   Parametrised data/return stack for the 3-bit Forth core: pointer register with

---
 rtl/stack_ptr_unit.sv | 119 +++++++++++
 tb/tb_stack_ptr_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/stack_ptr_unit.sv
// Guarded data/return stack for the 3-bit Forth core: pointer, storage, top-of-stack and sticky error flags.
// Optional feature: define STACK_PEEK_EN to add the peek_idx/peek_data read port (OVER/PICK support).
module stack_ptr_unit #(
    parameter int DATA_W = 12,
    parameter int PTR_W  = 12,
    parameter int DEPTH  = 16,
    parameter int BASE   = 75
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 op,
    input  logic [DATA_W-1:0]          din,
    input  logic [PTR_W-1:0]           ptr_in,
    input  logic                       err_clr,
`ifdef STACK_PEEK_EN
    input  logic [$clog2(DEPTH)-1:0]   peek_idx,
    output logic [DATA_W-1:0]          peek_data,
`endif
    output logic [PTR_W-1:0]           ptr_out,
    output logic [DATA_W-1:0]          tos,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       ovf,
    output logic                       unf,
    output logic                       ld_err
);

    localparam int              IDX_W  = $clog2(DEPTH);
    localparam int              CNT_W  = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] BASE_P = PTR_W'(BASE);
    localparam logic [PTR_W-1:0] TOP_P  = PTR_W'(BASE + DEPTH);
    localparam logic [PTR_W-1:0] ONE_P  = PTR_W'(1);

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_LOAD = 2'b11
    } op_e;

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              ld_err_q, ld_err_d;
    logic              mem_we;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  tos_idx;
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Status is decoded straight from the pointer so it never lags it.
    assign ptr_out = ptr_q;
    assign empty   = (ptr_q == BASE_P);
    assign full    = (ptr_q == TOP_P);
    assign count   = CNT_W'(ptr_q - BASE_P);
    assign wr_idx  = IDX_W'(ptr_q - BASE_P);
    assign tos_idx = IDX_W'(ptr_q - BASE_P - ONE_P);
    assign tos     = empty ? '0 : mem_q[tos_idx];
    assign ovf     = ovf_q;
    assign unf     = unf_q;
    assign ld_err  = ld_err_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        ptr_d    = ptr_q;
        mem_we   = 1'b0;
        // A clear drops old flags; a new error below is ORed back in, so set wins.
        ovf_d    = err_clr ? 1'b0 : ovf_q;
        unf_d    = err_clr ? 1'b0 : unf_q;
        ld_err_d = err_clr ? 1'b0 : ld_err_q;
        case (op_e'(op))
            OP_PUSH: begin
                if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    mem_we = 1'b1;
                    ptr_d  = ptr_q + ONE_P;
                end
            end
            OP_POP: begin
                if (empty) unf_d = 1'b1;
                else       ptr_d = ptr_q - ONE_P;
            end
            OP_LOAD: begin
                if (ptr_in >= BASE_P && ptr_in <= TOP_P) ptr_d    = ptr_in;
                else                                     ld_err_d = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= BASE_P;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            ld_err_q <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            ld_err_q <= ld_err_d;
        end
    end

    // NOTE: storage has no reset; tos/peek mask stale entries via the pointer instead.
    always_ff @(negedge clk) begin
        if (mem_we) mem_q[wr_idx] <= din;
    end

`ifdef STACK_PEEK_EN
    logic [IDX_W-1:0] peek_sel;

    assign peek_sel  = IDX_W'(ptr_q - BASE_P - ONE_P - PTR_W'(peek_idx));
    assign peek_data = (CNT_W'(peek_idx) < count) ? mem_q[peek_sel] : '0;
`endif

endmodule

// File: tb/tb_stack_ptr_unit.sv
// Directed bench for stack_ptr_unit: vector table plus hand sequences for reset, fill/overflow and peek.
module tb_stack_ptr_unit;

    localparam int DATA_W = 12;
    localparam int PTR_W  = 12;
    localparam int DEPTH  = 16;
    localparam int BASE   = 75;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        op;
    logic [DATA_W-1:0] din;
    logic [PTR_W-1:0]  ptr_in;
    logic              err_clr;
    logic [PTR_W-1:0]  ptr_out;
    logic [DATA_W-1:0] tos;
    logic [4:0]        count;
    logic              empty, full, ovf, unf, ld_err;
`ifdef STACK_PEEK_EN
    logic [3:0]        peek_idx;
    logic [DATA_W-1:0] peek_data;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    stack_ptr_unit #(.DATA_W(DATA_W), .PTR_W(PTR_W), .DEPTH(DEPTH), .BASE(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .din(din), .ptr_in(ptr_in), .err_clr(err_clr),
`ifdef STACK_PEEK_EN
        .peek_idx(peek_idx), .peek_data(peek_data),
`endif
        .ptr_out(ptr_out), .tos(tos), .count(count), .empty(empty), .full(full),
        .ovf(ovf), .unf(unf), .ld_err(ld_err)
    );

    typedef struct {
        logic [1:0]  op;
        logic [11:0] din;
        logic [11:0] ptr_in;
        logic        clr;
        logic [11:0] e_ptr;
        logic [11:0] e_tos;
        logic [4:0]  e_cnt;
        logic        e_empty, e_full, e_ovf, e_unf, e_ld;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] o, input logic [11:0] d, input logic [11:0] p, input logic c,
                       input logic [11:0] ep, input logic [11:0] et, input logic [4:0] ec,
                       input logic ee, input logic ef, input logic eo, input logic eu, input logic el);
        vec_t v;
        v = '{o, d, p, c, ep, et, ec, ee, ef, eo, eu, el};
        vecs.push_back(v);
    endtask

    // Drive on the rising edge, let the falling edge update state, sample just after it.
    task automatic step(input logic [1:0] o, input logic [11:0] d, input logic [11:0] p, input logic c);
        @(posedge clk);
        op = o; din = d; ptr_in = p; err_clr = c;
        @(negedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input vec_t v);
        check({tag, " ptr"},   32'(ptr_out), 32'(v.e_ptr));
        check({tag, " tos"},   32'(tos),     32'(v.e_tos));
        check({tag, " count"}, 32'(count),   32'(v.e_cnt));
        check({tag, " empty"}, 32'(empty),   32'(v.e_empty));
        check({tag, " full"},  32'(full),    32'(v.e_full));
        check({tag, " ovf"},   32'(ovf),     32'(v.e_ovf));
        check({tag, " unf"},   32'(unf),     32'(v.e_unf));
        check({tag, " ld_err"},32'(ld_err),  32'(v.e_ld));
    endtask

    localparam logic [1:0] H = 2'b00, PU = 2'b01, PO = 2'b10, LD = 2'b11;

    initial begin
        vec_t rv;
        rst_n = 1'b0; op = H; din = '0; ptr_in = '0; err_clr = 1'b0;
`ifdef STACK_PEEK_EN
        peek_idx = '0;
`endif
        repeat (2) @(posedge clk);
        rst_n = 1'b1;
        #1;
        rv = '{H, 12'h0, 12'h0, 1'b0, 12'd75, 12'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        check_all("reset", rv);

        // Reset asserted mid-push: pending op discarded, outputs return to empty at once.
        step(PU, 12'h0AA, 12'h0, 1'b0);
        step(PU, 12'h0BB, 12'h0, 1'b0);
        check("pre-reset ptr", 32'(ptr_out), 32'd77);
        @(posedge clk);
        op = PU; din = 12'h0CC;
        #2 rst_n = 1'b0;
        #1;
        check_all("mid-push reset", rv);
        @(negedge clk);
        #1 check("reset held ptr", 32'(ptr_out), 32'd75);
        @(posedge clk);
        op = H; rst_n = 1'b1;

        // Fill from empty: 16 pushes reach full, the 17th overflows without moving anything.
        for (int i = 0; i < DEPTH; i++) begin
            step(PU, 12'(12'h100 + i), 12'h0, 1'b0);
            if (i == DEPTH - 2) check("fill 15 full", 32'(full), 32'd0);
        end
        check("fill full",  32'(full),    32'd1);
        check("fill ptr",   32'(ptr_out), 32'd91);
        check("fill count", 32'(count),   32'd16);
        check("fill tos",   32'(tos),     32'h10F);
        check("fill ovf",   32'(ovf),     32'd0);
        step(PU, 12'h1FF, 12'h0, 1'b0);
        check("ovf ptr", 32'(ptr_out), 32'd91);
        check("ovf set", 32'(ovf),     32'd1);
        check("ovf tos", 32'(tos),     32'h10F);

        // Storage now holds 0x100+i at slot i; rows below rely on that.
        //  op  din     ptr_in  clr   ptr     tos     cnt   emp   full  ovf   unf   ld
        add(LD, 12'h0,  12'd75, 1'b1, 12'd75, 12'h0,   5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(PU, 12'h00A,12'd0,  1'b0, 12'd76, 12'h00A, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(PU, 12'h00B,12'd0,  1'b0, 12'd77, 12'h00B, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(PU, 12'h00C,12'd0,  1'b0, 12'd78, 12'h00C, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(PO, 12'h0,  12'd0,  1'b0, 12'd77, 12'h00B, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(H,  12'h0,  12'd0,  1'b0, 12'd77, 12'h00B, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(PO, 12'h0,  12'd0,  1'b0, 12'd76, 12'h00A, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(PO, 12'h0,  12'd0,  1'b0, 12'd75, 12'h0,   5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(PO, 12'h0,  12'd0,  1'b0, 12'd75, 12'h0,   5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        add(PU, 12'h123,12'd0,  1'b0, 12'd76, 12'h123, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        add(LD, 12'h0,  12'd80, 1'b0, 12'd80, 12'h104, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        add(LD, 12'h0,  12'd100,1'b0, 12'd80, 12'h104, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        add(LD, 12'h0,  12'd75, 1'b0, 12'd75, 12'h0,   5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        add(PO, 12'h0,  12'd0,  1'b1, 12'd75, 12'h0,   5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        add(LD, 12'h0,  12'd91, 1'b0, 12'd91, 12'h10F, 5'd16,1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        add(PU, 12'h777,12'd0,  1'b0, 12'd91, 12'h10F, 5'd16,1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        add(LD, 12'h0,  12'd74, 1'b0, 12'd91, 12'h10F, 5'd16,1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        add(PO, 12'h0,  12'd0,  1'b0, 12'd90, 12'h10E, 5'd15,1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        add(H,  12'h0,  12'd0,  1'b1, 12'd90, 12'h10E, 5'd15,1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(LD, 12'h0,  12'd0,  1'b0, 12'd90, 12'h10E, 5'd15,1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        add(LD, 12'h0,  12'd75, 1'b0, 12'd75, 12'h0,   5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        add(PO, 12'h0,  12'd0,  1'b1, 12'd75, 12'h0,   5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        foreach (vecs[i]) begin
            step(vecs[i].op, vecs[i].din, vecs[i].ptr_in, vecs[i].clr);
            check_all($sformatf("v%0d", i), vecs[i]);
        end

`ifdef STACK_PEEK_EN
        step(LD, 12'h0, 12'd75, 1'b1);
        step(PU, 12'h001, 12'h0, 1'b0);
        step(PU, 12'h002, 12'h0, 1'b0);
        step(PU, 12'h003, 12'h0, 1'b0);
        peek_idx = 4'd0;  #1 check("peek 0",  32'(peek_data), 32'h3);
        peek_idx = 4'd1;  #1 check("peek 1",  32'(peek_data), 32'h2);
        peek_idx = 4'd2;  #1 check("peek 2",  32'(peek_data), 32'h1);
        peek_idx = 4'd3;  #1 check("peek 3",  32'(peek_data), 32'h0);
        peek_idx = 4'd15; #1 check("peek 15", 32'(peek_data), 32'h0);
        check("peek ptr", 32'(ptr_out), 32'd78);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
